// File: rtl/collatz_swbut_input.sv
// collatz_swbut_input: switch/button front end for the Collatz switch/button top.
// The raw bus is in[WIDTH] = push button and in[WIDTH-1:0] = switches. Every bit is
// synchronised. The button is debounced. Each clean press becomes one valid/ready
// request that carries the switch value captured at the press.
// A zero operand is rejected because Collatz(0) never terminates. Rejected presses
// and presses made while a request is pending are counted in drop_count, which
// saturates at 255.
// Optional autorepeat while the button is held: define SWBUT_AUTOREPEAT_EN.
module collatz_swbut_input #(
  parameter int WIDTH           = 15,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:0]   in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [7:0]       drop_count
);

  // Elaboration-time sanity limits on the configuration
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("collatz_swbut_input: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("collatz_swbut_input: DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rpt
    $error("collatz_swbut_input: REPEAT_CYCLES must be at least 1");
  end

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HELD = 2'd2
  } state_t;

  // Saturating increment for the drop counter
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [WIDTH:0]   sync_q [SYNC_STAGES];
  logic             btn_sync;
  logic [WIDTH-1:0] sw_sync;

  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             btn_stable_q, btn_stable_d;
  logic             btn_prev_q;
  logic             press;

  state_t           state_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [7:0]       drop_q;

`ifdef SWBUT_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_q;
`endif

  // Multi-flop synchroniser on every bus bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1][WIDTH];
  assign sw_sync  = sync_q[SYNC_STAGES-1][WIDTH-1:0];

  // Debounce next state: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    db_cnt_d     = db_cnt_q;
    btn_stable_d = btn_stable_q;
    if (btn_sync == btn_stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_stable_d = btn_sync;
      db_cnt_d     = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Debounce state and the one-cycle-delayed copy used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q     <= '0;
      btn_stable_q <= 1'b0;
      btn_prev_q   <= 1'b0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      btn_stable_q <= btn_stable_d;
      btn_prev_q   <= btn_stable_q;
    end
  end

  assign press = btn_stable_q & ~btn_prev_q;

  // Request FSM: capture on press, hold the request until the transfer, then wait for release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
`ifdef SWBUT_AUTOREPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            if (sw_sync != '0) begin
              out_data_q  <= sw_sync;
              out_valid_q <= 1'b1;
              state_q     <= PEND;
            end else begin
              drop_q  <= sat_inc(drop_q);
              state_q <= HELD;
`ifdef SWBUT_AUTOREPEAT_EN
              rpt_q   <= '0;
`endif
            end
          end
        end
        PEND: begin
          // A release and re-press before the transfer cannot be queued
          if (press) drop_q <= sat_inc(drop_q);
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            if (btn_stable_q) begin
              state_q <= HELD;
`ifdef SWBUT_AUTOREPEAT_EN
              rpt_q   <= '0;
`endif
            end else begin
              state_q <= IDLE;
            end
          end
        end
        HELD: begin
          if (!btn_stable_q) begin
            state_q <= IDLE;
          end
`ifdef SWBUT_AUTOREPEAT_EN
          else if (rpt_q == RPT_LAST) begin
            // The repeat interval has elapsed, so treat it like a fresh press seen in IDLE
            rpt_q <= '0;
            if (sw_sync != '0) begin
              out_data_q  <= sw_sync;
              out_valid_q <= 1'b1;
              state_q     <= PEND;
            end else begin
              drop_q <= sat_inc(drop_q);
            end
          end else begin
            rpt_q <= rpt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_collatz_swbut_input.sv
// Directed bench for collatz_swbut_input with default parameters.
// REPEAT_CYCLES is set to 32 so that an autorepeat build exercises the short interval.
module tb_collatz_swbut_input;

  logic        clk;
  logic        rst;
  logic [15:0] in_bus;
  logic [14:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;
  int xfer_data = 0;
  int cyc = 0;
  int xfer_cyc_last = 0;
  int xfer_cyc_prev = 0;
  int ok;

  collatz_swbut_input #(
    .WIDTH(15),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(16),
    .REPEAT_CYCLES(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in_bus),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record completed transfers: values seen just before each active edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && out_valid && out_ready) begin
      xfer_cnt      <= xfer_cnt + 1;
      xfer_data     <= int'(out_data);
      xfer_cyc_prev <= xfer_cyc_last;
      xfer_cyc_last <= cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_bus = 16'h0000;
    out_ready = 1'b1;
    step(3);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drop", int'(drop_count), 0);
    rst = 1'b0;
    step(2);

    // Held press with switches=1: request after edge 18, single transfer, busy until release
    in_bus = 16'h8001;
    ok = 1;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      if (out_valid) ok = 0;
    end
    chk("t1_no_early_valid", ok, 1);
    step(1);
    chk("t1_valid_edge18", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 1);
    step(1);
    chk("t1_valid_drop", int'(out_valid), 0);
    chk("t1_xfer_cnt", xfer_cnt, 1);
    chk("t1_xfer_data", xfer_data, 1);
    chk("t1_busy_held", int'(busy), 1);
    step(50);
    chk("t1_no_repeat", xfer_cnt, 1);
    chk("t1_still_busy", int'(busy), 1);
    in_bus = 16'h0000;
    step(5);
    chk("t1_busy_release_early", int'(busy), 1);
    step(20);
    chk("t1_busy_idle", int'(busy), 0);

    // 10-cycle glitch ignored, then a 40-cycle hold gives one request of 27
    in_bus = {1'b1, 15'd27};
    step(10);
    in_bus = {1'b0, 15'd27};
    step(30);
    chk("t2_glitch_xfer", xfer_cnt, 1);
    chk("t2_glitch_drop", int'(drop_count), 0);
    chk("t2_glitch_busy", int'(busy), 0);
    in_bus = {1'b1, 15'd27};
    step(40);
    chk("t2_hold_xfer", xfer_cnt, 2);
    chk("t2_hold_data", xfer_data, 27);
    in_bus = 16'h0000;
    step(25);
    chk("t2_idle", int'(busy), 0);

    // Backpressure: data frozen, a re-press is dropped, and the transfer is single
    out_ready = 1'b0;
    in_bus = {1'b1, 15'd7};
    step(19);
    chk("t3_valid", int'(out_valid), 1);
    chk("t3_data", int'(out_data), 7);
    in_bus = {1'b1, 15'd9};
    step(5);
    chk("t3_data_frozen", int'(out_data), 7);
    in_bus = {1'b0, 15'd9};
    step(25);
    chk("t3_valid_kept", int'(out_valid), 1);
    chk("t3_drop_before", int'(drop_count), 0);
    in_bus = {1'b1, 15'd9};
    step(25);
    chk("t3_drop_repress", int'(drop_count), 1);
    chk("t3_data_after", int'(out_data), 7);
    chk("t3_valid_after", int'(out_valid), 1);
    out_ready = 1'b1;
    step(1);
    chk("t3_valid_low", int'(out_valid), 0);
    chk("t3_xfer_cnt", xfer_cnt, 3);
    chk("t3_xfer_data", xfer_data, 7);
    step(10);
    chk("t3_single", xfer_cnt, 3);
    in_bus = 16'h0000;
    step(25);
    chk("t3_idle", int'(busy), 0);

    // Zero operand is rejected, and drop_count saturates at 255
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    in_bus = 16'h8000;
    step(25);
    chk("t4_zero_drop", int'(drop_count), 1);
    chk("t4_zero_valid", int'(out_valid), 0);
    chk("t4_zero_busy", int'(busy), 1);
    in_bus = 16'h0000;
    step(25);
    chk("t4_zero_idle", int'(busy), 0);
    for (int p = 0; p < 300; p++) begin
      in_bus = 16'h8000;
      step(20);
      in_bus = 16'h0000;
      step(20);
    end
    chk("t4_drop_sat", int'(drop_count), 255);
    chk("t4_no_xfer", xfer_cnt, 3);

    // Reset while a request is pending, with the button held across reset release
    out_ready = 1'b0;
    in_bus = {1'b1, 15'd3};
    step(19);
    chk("t5_valid", int'(out_valid), 1);
    chk("t5_data", int'(out_data), 3);
    rst = 1'b1;
    #1;
    chk("t5_async_valid", int'(out_valid), 0);
    chk("t5_async_drop", int'(drop_count), 0);
    chk("t5_async_busy", int'(busy), 0);
    step(2);
    rst = 1'b0;
    ok = 1;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      if (out_valid) ok = 0;
    end
    chk("t5_no_early_valid", ok, 1);
    step(1);
    chk("t5_valid_again", int'(out_valid), 1);
    chk("t5_data_again", int'(out_data), 3);
    out_ready = 1'b1;
    step(1);
    chk("t5_xfer_cnt", xfer_cnt, 4);
    chk("t5_xfer_data", xfer_data, 3);
    in_bus = 16'h0000;
    step(25);
    chk("t5_idle", int'(busy), 0);

`ifdef SWBUT_AUTOREPEAT_EN
    // Autorepeat with REPEAT_CYCLES=32: transfers 33 edges apart
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    out_ready = 1'b1;
    in_bus = 16'h8005;
    step(200);
    chk("t6_rpt_count", xfer_cnt, 10);
    chk("t6_rpt_data", xfer_data, 5);
    chk("t6_rpt_interval", xfer_cyc_last - xfer_cyc_prev, 33);
    in_bus = 16'h0000;
    step(25);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
